// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
//
// Purpose:
//   Bundles every signal between alu_arbiter and its surroundings: the
//   two requester request channels, the shared response channel, and the
//   operand/opcode/result wires to the external single-cycle ALU.
//
// Signals:
//   req_valid[1:0]   requester i presents an operation
//   req_ready[1:0]   requester i accepted this cycle (one-hot or zero)
//   req0_a/b/op      requester 0 operands and ALUOp
//   req1_a/b/op      requester 1 operands and ALUOp
//   rsp_valid[1:0]   result available for requester i (one-hot or zero)
//   rsp_ready[1:0]   requester i takes the result
//   rsp_c, rsp_zero  registered ALU result and Zero flag
//   alu_a/b/op       operands and opcode driven to the ALU
//   alu_c, alu_zero  ALU result and Zero flag
//
// Modports:
//   master  the environment: requesters plus the ALU itself
//   slave   the arbiter
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_c;
    logic             rsp_zero;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_c;
    logic             alu_zero;

    modport master (
        output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        output rsp_ready,
        output alu_c, alu_zero,
        input  req_ready, rsp_valid, rsp_c, rsp_zero,
        input  alu_a, alu_b, alu_op
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
        input  rsp_ready,
        input  alu_c, alu_zero,
        output req_ready, rsp_valid, rsp_c, rsp_zero,
        output alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external single-cycle ALU between two requesters (0: core
//   multi-cycle datapath, 1: auxiliary unit). Round-robin arbitration in
//   IDLE, operands captured on accept, ALU driven for one EXEC cycle, result
//   registered and held on a valid/ready response channel to the winner.
//
//   IDLE --accept--> EXEC --always--> RESP --rsp handshake--> IDLE
//   Accept-to-response latency is 2 cycles; minimum issue interval is 3.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   alu_arbiter_if.slave: request, response and ALU signals
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // ALUOp encoding of the no-operation opcode (matches ctrl_encode_def.v).
    localparam logic [3:0] ALU_NOP = 4'b0000;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [3:0]       r_op_code;
    logic [WIDTH-1:0] r_rsp_c;
    logic             r_rsp_zero;
    logic             r_grant;
    logic             r_last_grant;

    logic             w_idle;
    logic             w_win;
    logic             w_accept;
    logic             w_rsp_done;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [3:0]       w_sel_op;

    // Arbitration. Gating with rst keeps req_ready low while reset is held,
    // even though the state register already reads IDLE.
    always_comb begin
        w_idle = (r_state == S_IDLE) && !rst;
        w_win  = 1'b0;
        case (bus.req_valid)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last_grant;  // tie: whoever was not served last
            default: w_win = 1'b0;
        endcase
        w_accept = w_idle && (bus.req_valid != 2'b00);
    end

    always_comb begin
        w_sel_a  = w_win ? bus.req1_a  : bus.req0_a;
        w_sel_b  = w_win ? bus.req1_b  : bus.req0_b;
        w_sel_op = w_win ? bus.req1_op : bus.req0_op;
    end

    // Only the granted requester's rsp_ready bit can end RESP.
    assign w_rsp_done = (r_state == S_RESP) && bus.rsp_ready[r_grant];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_RESP;
            S_RESP:  if (w_rsp_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_code    <= ALU_NOP;
            r_rsp_c      <= '0;
            r_rsp_zero   <= 1'b0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;  // requester 0 wins the first tie
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op_a       <= w_sel_a;
                r_op_b       <= w_sel_b;
                r_op_code    <= w_sel_op;
                r_grant      <= w_win;
                r_last_grant <= w_win;
            end
            if (r_state == S_EXEC) begin
                r_rsp_c    <= bus.alu_c;
                r_rsp_zero <= bus.alu_zero;
            end
        end
    end

    always_comb begin
        bus.req_ready = 2'b00;
        if (w_accept) begin
            bus.req_ready = w_win ? 2'b10 : 2'b01;
        end
        bus.rsp_valid = 2'b00;
        if (r_state == S_RESP) begin
            bus.rsp_valid = r_grant ? 2'b10 : 2'b01;
        end
        bus.rsp_c    = r_rsp_c;
        bus.rsp_zero = r_rsp_zero;
        bus.alu_a    = r_op_a;
        bus.alu_b    = r_op_b;
        // Hold the ALU on NOP outside EXEC so it stays inert.
        bus.alu_op   = (r_state == S_EXEC) ? r_op_code : ALU_NOP;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Purpose:
//   Directed self-checking bench for alu_arbiter. Supplies a behavioural ALU,
//   queues the expected response of every accepted request and compares it
//   when the response appears.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLTU = 4'h6;
    localparam logic [3:0] OP_NOR  = 4'h7;

    typedef struct packed {
        int          idx;
        logic [31:0] c;
        logic        z;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   g_cyc   = 0;
    int   rsp_cyc = 0;
    int   waited  = 0;
    int   c0      = 0;
    exp_t sb[$];

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'b0, a < b};
            OP_NOR:  return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        bus.alu_c    = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
        bus.alu_zero = (alu_fn(bus.alu_op, bus.alu_a, bus.alu_b) == 32'h0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for an accept, check it went to idx, queue the result.
    task automatic wait_grant(input string tag, input int idx, input logic [31:0] c,
                              input logic z, output int w);
        w = 0;
        @(negedge clk);
        while (bus.req_ready == 2'b00 && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk(tag, {62'b0, bus.req_ready}, 64'(1) << idx);
        sb.push_back('{idx: idx, c: c, z: z});
        g_cyc = cyc;
        step();
    endtask

    // Wait (bounded) for a response, compare against the queue head.
    task automatic wait_rsp(input string tag);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (bus.rsp_valid == 2'b00 && n < 8) begin
            @(negedge clk);
            n++;
        end
        rsp_cyc = cyc;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, {62'b0, bus.rsp_valid}, 64'(1) << e.idx);
            chk({tag, "_c"}, {32'b0, bus.rsp_c}, {32'b0, e.c});
            chk({tag, "_zero"}, {63'b0, bus.rsp_zero}, {63'b0, e.z});
        end
        step();
    endtask

    task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        if (idx == 0) begin
            bus.req0_op = op;
            bus.req0_a  = a;
            bus.req0_b  = b;
        end else begin
            bus.req1_op = op;
            bus.req1_a  = a;
            bus.req1_b  = b;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        set_req(0, OP_NOP, 32'h0, 32'h0);
        set_req(1, OP_NOP, 32'h0, 32'h0);

        // Reset state, with both requests pending.
        @(negedge clk);
        chk("rst_req_ready", {62'b0, bus.req_ready}, 64'd0);
        chk("rst_rsp_valid", {62'b0, bus.rsp_valid}, 64'd0);
        chk("rst_alu_op", {60'b0, bus.alu_op}, {60'b0, OP_NOP});
        chk("rst_rsp_c", {32'b0, bus.rsp_c}, 64'd0);
        chk("rst_rsp_zero", {63'b0, bus.rsp_zero}, 64'd0);
        bus.req_valid = 2'b00;
        step();
        rst = 1'b0;

        // Single request: ADD 5+7 from requester 0.
        set_req(0, OP_ADD, 32'd5, 32'd7);
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("single_ready", {62'b0, bus.req_ready}, 64'b01);
        chk("single_idle_op", {60'b0, bus.alu_op}, {60'b0, OP_NOP});
        sb.push_back('{idx: 0, c: 32'd12, z: 1'b0});
        g_cyc = cyc;
        step();
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("single_exec_op", {60'b0, bus.alu_op}, {60'b0, OP_ADD});
        chk("single_exec_rsp", {62'b0, bus.rsp_valid}, 64'd0);
        chk("single_exec_ready", {62'b0, bus.req_ready}, 64'd0);
        step();
        wait_rsp("single");
        chk("single_latency", 64'(rsp_cyc - g_cyc), 64'd2);
        @(negedge clk);
        chk("single_after_op", {60'b0, bus.alu_op}, {60'b0, OP_NOP});
        chk("single_after_rsp", {62'b0, bus.rsp_valid}, 64'd0);
        step();

        // Tie after reset.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_req(0, OP_OR, 32'hF0, 32'h0F);
        set_req(1, OP_SUB, 32'd9, 32'd9);
        bus.req_valid = 2'b11;
        wait_grant("tie_first", 0, 32'hFF, 1'b0, waited);
        bus.req_valid = 2'b10;
        wait_rsp("tie_r0");
        wait_grant("tie_second", 1, 32'h0, 1'b1, waited);
        chk("tie_second_wait", 64'(waited), 64'd0);
        bus.req_valid = 2'b00;
        wait_rsp("tie_r1");

        // Fairness: both held valid for 6 grants (last grant was 1).
        set_req(0, OP_ADD, 32'd1, 32'd2);
        set_req(1, OP_SUB, 32'd10, 32'd3);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) wait_grant("fair_grant", 0, 32'd3, 1'b0, waited);
            else            wait_grant("fair_grant", 1, 32'd7, 1'b0, waited);
            if (i == 5) bus.req_valid = 2'b00;
            wait_rsp("fair_rsp");
        end

        // Requester 0 alone: three back-to-back grants, 3 cycles apart.
        bus.req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            c0 = g_cyc;
            wait_grant("solo_grant", 0, 32'd3, 1'b0, waited);
            if (i > 0) chk("solo_interval", 64'(g_cyc - c0), 64'd3);
            if (i == 2) bus.req_valid = 2'b00;
            wait_rsp("solo_rsp");
        end

        // Backpressure; the non-granted rsp_ready bit is high and must be ignored.
        bus.rsp_ready = 2'b01;
        set_req(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        bus.req_valid = 2'b10;
        wait_grant("bp_grant", 1, 32'd1, 1'b0, waited);
        set_req(0, OP_ADD, 32'd5, 32'd7);
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("bp_exec_ready", {62'b0, bus.req_ready}, 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {62'b0, bus.rsp_valid}, 64'b10);
            chk("bp_hold_c", {32'b0, bus.rsp_c}, 64'd1);
            chk("bp_hold_ready", {62'b0, bus.req_ready}, 64'd0);
            step();
        end
        bus.rsp_ready = 2'b10;
        wait_rsp("bp_rsp");
        wait_grant("bp_next", 0, 32'd12, 1'b0, waited);
        chk("bp_next_wait", 64'(waited), 64'd0);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        wait_rsp("bp_next_rsp");

        // Signedness.
        set_req(1, OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        bus.req_valid = 2'b10;
        wait_grant("sltu_grant", 1, 32'd0, 1'b1, waited);
        bus.req_valid = 2'b00;
        wait_rsp("sltu");
        set_req(0, OP_NOR, 32'd0, 32'd0);
        bus.req_valid = 2'b01;
        wait_grant("nor_grant", 0, 32'hFFFF_FFFF, 1'b0, waited);
        bus.req_valid = 2'b00;
        wait_rsp("nor");

        // Reset during EXEC; rsp_c currently holds 0xFFFFFFFF.
        set_req(0, OP_ADD, 32'd5, 32'd7);
        bus.req_valid = 2'b01;
        wait_grant("rx_grant", 0, 32'd12, 1'b0, waited);
        chk("rx_exec_op", {60'b0, bus.alu_op}, {60'b0, OP_ADD});
        rst = 1'b1;
        #1;
        chk("rx_rsp_valid", {62'b0, bus.rsp_valid}, 64'd0);
        chk("rx_alu_op", {60'b0, bus.alu_op}, {60'b0, OP_NOP});
        chk("rx_rsp_c", {32'b0, bus.rsp_c}, 64'd0);
        chk("rx_req_ready", {62'b0, bus.req_ready}, 64'd0);
        sb.delete();
        set_req(1, OP_SUB, 32'd9, 32'd9);
        bus.req_valid = 2'b11;
        step();
        rst = 1'b0;
        wait_grant("rx_tie", 0, 32'd12, 1'b0, waited);
        bus.req_valid = 2'b00;
        wait_rsp("rx_after");

        // Reset during RESP.
        set_req(0, OP_OR, 32'hF0, 32'h0F);
        bus.req_valid = 2'b01;
        wait_grant("rr_grant", 0, 32'hFF, 1'b0, waited);
        bus.req_valid = 2'b00;
        step();
        chk("rr_resp_valid", {62'b0, bus.rsp_valid}, 64'b01);
        chk("rr_resp_c", {32'b0, bus.rsp_c}, 64'hFF);
        rst = 1'b1;
        #1;
        chk("rr_rsp_valid", {62'b0, bus.rsp_valid}, 64'd0);
        chk("rr_rsp_c", {32'b0, bus.rsp_c}, 64'd0);
        chk("rr_alu_op", {60'b0, bus.alu_op}, {60'b0, OP_NOP});
        sb.delete();
        set_req(0, OP_ADD, 32'd1, 32'd2);
        set_req(1, OP_SUB, 32'd10, 32'd3);
        bus.req_valid = 2'b11;
        step();
        rst = 1'b0;
        wait_grant("rr_tie", 0, 32'd3, 1'b0, waited);
        bus.req_valid = 2'b00;
        wait_rsp("rr_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
